// File: rtl/bk_sd_xfer.sv
// bk_sd_xfer: backup-RAM transfer controller between cartridge save RAM and
// SD-mounted save images.
//
// It moves whole save images one 512-byte sector at a time over an
// ack-handshaked SD channel. It also handles load-over-save arbitration,
// a per-sector ack timeout, abort on a new ROM download and auto-load
// after a download.
//
// Optional build macro: BK_AUTOSAVE_EN. When it is defined, the block saves
// image 0 after BSRAM writes have been quiet for AUTO_DLY cycles. Without
// the macro, bsram_wr is ignored.
//
// Ports
//   clk_sys, reset_n        clock, asynchronous active-low reset
//   rom_loading             ROM download active; a rising edge aborts
//   img_mounted/readonly/size_nz   mount strobes and image properties
//   img_sel                 image targeted by manual load/save requests
//   load_req, save_req      level requests; a rising edge starts a transfer
//   last_sect               index of the final sector (sampled at accept)
//   bsram_wr                BSRAM write strobe (dirty tracking, optional)
//   sd_ack                  SD ack per image
//   sd_lba                  current sector; also the BSRAM port-B address
//   sd_rd, sd_wr            one-hot read/write request per image
//   bk_loading, busy, done, error, ena   status outputs
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no transfer; requests are accepted here only
// WAIT_HI  | request asserted, waiting for the ack rising edge
// WAIT_LO  | request dropped, waiting for the ack falling edge
// NEXT     | one-cycle gap before the request for the next sector
// DONE     | pulse done and release busy/bk_loading
module bk_sd_xfer #(
    parameter int          NUM_IMG  = 2,
    parameter int          LBA_W    = 32,
    parameter int          SECT_W   = 15,
    parameter logic [23:0] ACK_TO   = 24'd4000000,
    parameter logic [23:0] AUTO_DLY = 24'd8000000,
    localparam int         SEL_W    = (NUM_IMG > 1) ? $clog2(NUM_IMG) : 1
) (
    input  logic               clk_sys,
    input  logic               reset_n,
    input  logic               rom_loading,
    input  logic [NUM_IMG-1:0] img_mounted,
    input  logic               img_readonly,
    input  logic               img_size_nz,
    input  logic [SEL_W-1:0]   img_sel,
    input  logic               load_req,
    input  logic               save_req,
    input  logic [SECT_W-1:0]  last_sect,
    input  logic               bsram_wr,
    input  logic [NUM_IMG-1:0] sd_ack,
    output logic [LBA_W-1:0]   sd_lba,
    output logic [NUM_IMG-1:0] sd_rd,
    output logic [NUM_IMG-1:0] sd_wr,
    output logic               bk_loading,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [NUM_IMG-1:0] ena
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT_HI, ST_WAIT_LO, ST_NEXT, ST_DONE
    } state_t;

    state_t             state_q;
    logic               rom_q, ld_q, sv_q;
    logic [NUM_IMG-1:0] ack_q, ena_q, rd_q, wr_q;
    logic [SEL_W-1:0]   ch_q;
    logic               is_load_q;
    logic [SECT_W-1:0]  last_q;
    logic [LBA_W-1:0]   lba_q;
    logic [23:0]        tmr_q;
    logic               bkl_q, busy_q, done_q, err_q;

    logic               rom_rise, rom_fall, sel_ok;
    logic               ld_d, sv_d, ld_rise, sv_rise;
    logic               ack_rise, ack_fall, at_last;
    logic               start, start_load;
    logic [SEL_W-1:0]   start_ch;
    logic [NUM_IMG-1:0] start_oh, ch_oh, ena_set;
    logic               auto_go;

    assign rom_rise = rom_loading & ~rom_q;
    assign rom_fall = ~rom_loading & rom_q;
    // Guards against img_sel values with no image behind them when NUM_IMG
    // is not a power of two.
    assign sel_ok   = int'(img_sel) < NUM_IMG;
    assign ld_d     = load_req & sel_ok & ena_q[img_sel];
    assign sv_d     = save_req & sel_ok & ena_q[img_sel];
    assign ld_rise  = ld_d & ~ld_q;
    assign sv_rise  = sv_d & ~sv_q;
    assign ack_rise = sd_ack[ch_q] & ~ack_q[ch_q];
    assign ack_fall = ~sd_ack[ch_q] & ack_q[ch_q];
    assign at_last  = lba_q >= LBA_W'(last_q);
    assign ch_oh    = NUM_IMG'(1) << ch_q;
    assign start_oh = NUM_IMG'(1) << start_ch;
    assign ena_set  = img_mounted & {NUM_IMG{rom_loading & img_size_nz & ~img_readonly}};

    // Auto-load after a download outranks manual requests; load beats save.
    always_comb begin
        start      = 1'b0;
        start_load = 1'b0;
        start_ch   = img_sel;
        if (rom_fall && ena_q[0]) begin
            start      = 1'b1;
            start_load = 1'b1;
            start_ch   = '0;
        end else if (ld_rise) begin
            start      = 1'b1;
            start_load = 1'b1;
        end else if (sv_rise) begin
            start      = 1'b1;
        end else if (auto_go) begin
            start      = 1'b1;
            start_ch   = '0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rom_q <= 1'b0;
            ld_q  <= 1'b0;
            sv_q  <= 1'b0;
            ack_q <= '0;
            ena_q <= '0;
        end else begin
            rom_q <= rom_loading;
            ld_q  <= ld_d;
            sv_q  <= sv_d;
            ack_q <= sd_ack;
            ena_q <= (rom_rise ? '0 : ena_q) | ena_set;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            rd_q      <= '0;
            wr_q      <= '0;
            ch_q      <= '0;
            is_load_q <= 1'b0;
            last_q    <= '0;
            lba_q     <= '0;
            tmr_q     <= '0;
            bkl_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (rom_rise) begin
                state_q <= ST_IDLE;
                rd_q    <= '0;
                wr_q    <= '0;
                bkl_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            ch_q      <= start_ch;
                            is_load_q <= start_load;
                            last_q    <= last_sect;
                            lba_q     <= '0;
                            bkl_q     <= start_load;
                            busy_q    <= 1'b1;
                            err_q     <= 1'b0;
                            rd_q      <= start_load ? start_oh : '0;
                            wr_q      <= start_load ? '0 : start_oh;
                            tmr_q     <= ACK_TO;
                            state_q   <= ST_WAIT_HI;
                        end
                    end
                    ST_WAIT_HI, ST_WAIT_LO: begin
                        // The timer runs from request assertion across both
                        // halves of the handshake.
                        if (tmr_q == '0) begin
                            err_q   <= 1'b1;
                            rd_q    <= '0;
                            wr_q    <= '0;
                            bkl_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            tmr_q <= tmr_q - 24'd1;
                            if (state_q == ST_WAIT_HI) begin
                                if (ack_rise) begin
                                    rd_q    <= '0;
                                    wr_q    <= '0;
                                    state_q <= ST_WAIT_LO;
                                end
                            end else if (ack_fall) begin
                                if (at_last) begin
                                    state_q <= ST_DONE;
                                end else begin
                                    lba_q   <= lba_q + LBA_W'(1);
                                    state_q <= ST_NEXT;
                                end
                            end
                        end
                    end
                    ST_NEXT: begin
                        rd_q    <= is_load_q ? ch_oh : '0;
                        wr_q    <= is_load_q ? '0 : ch_oh;
                        tmr_q   <= ACK_TO;
                        state_q <= ST_WAIT_HI;
                    end
                    ST_DONE: begin
                        done_q  <= 1'b1;
                        bkl_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef BK_AUTOSAVE_EN
    logic        dirty_q;
    logic [23:0] quiet_q;

    assign auto_go = dirty_q && (quiet_q == '0) && ena_q[0] && (state_q == ST_IDLE);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            dirty_q <= 1'b0;
            quiet_q <= '0;
        end else begin
            if (bsram_wr) begin
                quiet_q <= AUTO_DLY;
            end else if (quiet_q != '0) begin
                quiet_q <= quiet_q - 24'd1;
            end
            if (rom_loading) begin
                dirty_q <= 1'b0;
            end else begin
                // Any accepted save of image 0 captures the current RAM.
                // A write in the same cycle marks it dirty again.
                if (state_q == ST_IDLE && start && !start_load && start_ch == '0)
                    dirty_q <= 1'b0;
                if (bsram_wr && !bkl_q)
                    dirty_q <= 1'b1;
            end
        end
    end
`else
    logic unused_bsram_wr;
    assign unused_bsram_wr = bsram_wr;
    assign auto_go         = 1'b0;
`endif

    assign sd_lba     = lba_q;
    assign sd_rd      = rd_q;
    assign sd_wr      = wr_q;
    assign bk_loading = bkl_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = err_q;
    assign ena        = ena_q;

endmodule

// File: tb/tb_bk_sd_xfer.sv
module tb_bk_sd_xfer;
    localparam int NUM_IMG    = 2;
    localparam int LBA_W      = 32;
    localparam int SECT_W     = 15;
    localparam int ACK_TO_I   = 60;
    localparam int AUTO_DLY_I = 100;

    logic               clk_sys = 1'b0;
    logic               reset_n, rom_loading, img_readonly, img_size_nz;
    logic [NUM_IMG-1:0] img_mounted, sd_ack, sd_rd, sd_wr, ena;
    logic [0:0]         img_sel;
    logic               load_req, save_req, bsram_wr;
    logic [SECT_W-1:0]  last_sect;
    logic [LBA_W-1:0]   sd_lba;
    logic               bk_loading, busy, done, error;

    always #5 clk_sys = ~clk_sys;

    bk_sd_xfer #(
        .NUM_IMG(NUM_IMG), .LBA_W(LBA_W), .SECT_W(SECT_W),
        .ACK_TO(24'(ACK_TO_I)), .AUTO_DLY(24'(AUTO_DLY_I))
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .rom_loading(rom_loading),
        .img_mounted(img_mounted), .img_readonly(img_readonly),
        .img_size_nz(img_size_nz), .img_sel(img_sel), .load_req(load_req),
        .save_req(save_req), .last_sect(last_sect), .bsram_wr(bsram_wr),
        .sd_ack(sd_ack), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr),
        .bk_loading(bk_loading), .busy(busy), .done(done), .error(error),
        .ena(ena)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Inputs as seen at the last rising edge.
    logic        c_rst, c_rom, c_ld, c_sv, c_ro, c_nz, c_bw, c_sel;
    logic [1:0]  c_mnt, c_ack;
    logic [14:0] c_last;

    logic [1:0]  m_ena = '0, m_ackp = '0;
    logic        m_romp = 0, m_ldp = 0, m_svp = 0;
    logic        m_busy = 0, m_load = 0, m_req = 0, m_hi = 0, m_gap = 0, m_fin = 0;
    logic        m_bkl = 0, m_done = 0, m_err = 0, m_dirty = 0;
    int          m_ch = 0, m_lba = 0, m_last = 0, m_age = 0, m_quiet = 0;

    task automatic begin_xfer(input int ch, input logic ld);
        m_busy = 1; m_load = ld; m_ch = ch; m_lba = 0; m_last = int'(c_last);
        m_bkl = ld; m_err = 0; m_req = 1; m_hi = 0; m_gap = 0; m_fin = 0; m_age = 0;
    endtask

    task automatic model_step();
        logic rom_rise, rom_fall, ld_lvl, sv_lvl, ld_rise, sv_rise;
        logic a_rise, a_fall, bkl_prev, clr_dirty;
        if (!c_rst) begin
            m_ena = '0; m_ackp = '0; m_romp = 0; m_ldp = 0; m_svp = 0;
            m_busy = 0; m_load = 0; m_req = 0; m_hi = 0; m_gap = 0; m_fin = 0;
            m_bkl = 0; m_done = 0; m_err = 0; m_dirty = 0;
            m_ch = 0; m_lba = 0; m_last = 0; m_age = 0; m_quiet = 0;
            return;
        end
        rom_rise  = c_rom && !m_romp;
        rom_fall  = !c_rom && m_romp;
        ld_lvl    = c_ld && m_ena[c_sel];
        sv_lvl    = c_sv && m_ena[c_sel];
        ld_rise   = ld_lvl && !m_ldp;
        sv_rise   = sv_lvl && !m_svp;
        a_rise    = c_ack[m_ch] && !m_ackp[m_ch];
        a_fall    = !c_ack[m_ch] && m_ackp[m_ch];
        bkl_prev  = m_bkl;
        clr_dirty = 0;
        m_done    = 0;
        if (rom_rise) begin
            m_busy = 0; m_req = 0; m_bkl = 0; m_fin = 0; m_gap = 0;
        end else if (!m_busy) begin
            if (rom_fall && m_ena[0]) begin_xfer(0, 1);
            else if (ld_rise) begin_xfer(int'(c_sel), 1);
            else if (sv_rise) begin
                begin_xfer(int'(c_sel), 0);
                clr_dirty = (c_sel == 1'b0);
            end
`ifdef BK_AUTOSAVE_EN
            else if (m_dirty && m_quiet == 0 && m_ena[0]) begin
                begin_xfer(0, 0);
                clr_dirty = 1;
            end
`endif
        end else if (m_fin) begin
            m_done = 1; m_busy = 0; m_bkl = 0; m_fin = 0;
        end else if (m_gap) begin
            m_req = 1; m_gap = 0; m_age = 0;
        end else if (m_age == ACK_TO_I) begin
            m_err = 1; m_busy = 0; m_req = 0; m_bkl = 0;
        end else begin
            m_age++;
            if (!m_hi) begin
                if (a_rise) begin m_req = 0; m_hi = 1; end
            end else if (a_fall) begin
                m_hi = 0;
                if (m_lba >= m_last) m_fin = 1;
                else begin m_lba++; m_gap = 1; end
            end
        end
`ifdef BK_AUTOSAVE_EN
        if (c_rom) m_dirty = 0;
        else begin
            if (clr_dirty) m_dirty = 0;
            if (c_bw && !bkl_prev) m_dirty = 1;
        end
        if (c_bw) m_quiet = AUTO_DLY_I;
        else if (m_quiet != 0) m_quiet--;
`endif
        m_ena  = (rom_rise ? 2'b00 : m_ena) | ({2{c_rom && c_nz && !c_ro}} & c_mnt);
        m_romp = c_rom; m_ldp = ld_lvl; m_svp = sv_lvl; m_ackp = c_ack;
    endtask

    // Observation counters used by the directed checks.
    int         rd_n[2], wr_n[2];
    int         done_n = 0, max_lba = 0, bkl_gap = 0, bkl_hi = 0;
    logic [1:0] o_rdp = '0, o_wrp = '0;

    initial begin
        logic [1:0] exp_rd, exp_wr;
        rd_n = '{0, 0}; wr_n = '{0, 0};
        forever begin
            @(posedge clk_sys);
            c_rst = reset_n; c_rom = rom_loading; c_ld = load_req; c_sv = save_req;
            c_ro = img_readonly; c_nz = img_size_nz; c_bw = bsram_wr; c_sel = img_sel;
            c_mnt = img_mounted; c_ack = sd_ack; c_last = last_sect;
            @(negedge clk_sys);
            model_step();
            exp_rd = (m_req && m_load)  ? 2'(1 << m_ch) : 2'b00;
            exp_wr = (m_req && !m_load) ? 2'(1 << m_ch) : 2'b00;
            chk("sd_lba", 64'(sd_lba), 64'(m_lba));
            chk("sd_rd", 64'(sd_rd), 64'(exp_rd));
            chk("sd_wr", 64'(sd_wr), 64'(exp_wr));
            chk("bk_loading", 64'(bk_loading), 64'(m_bkl));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(m_done));
            chk("error", 64'(error), 64'(m_err));
            chk("ena", 64'(ena), 64'(m_ena));
            for (int i = 0; i < 2; i++) begin
                if (sd_rd[i] && !o_rdp[i]) rd_n[i]++;
                if (sd_wr[i] && !o_wrp[i]) wr_n[i]++;
            end
            o_rdp = sd_rd; o_wrp = sd_wr;
            if (done) done_n++;
            if (busy && int'(sd_lba) > max_lba) max_lba = int'(sd_lba);
            if (busy && !bk_loading && (sd_rd != 0)) bkl_gap++;
            if (busy && bk_loading) bkl_hi++;
        end
    end

    // ---------------- SD responder ----------------
    logic silent = 0, noise_en = 0;

    initial begin
        int  dly = 2, hold = 0, rch = 0;
        logic on = 0;
        sd_ack = '0;
        forever begin
            @(negedge clk_sys); #1;
            if (silent || !reset_n) begin
                sd_ack = '0; on = 0;
            end else if (!on) begin
                if ((sd_rd | sd_wr) != 2'b00) begin
                    rch = (sd_rd[1] | sd_wr[1]) ? 1 : 0;
                    if (dly == 0) begin
                        sd_ack[rch] = 1'b1; on = 1; hold = $urandom_range(0, 8);
                    end else dly--;
                end
            end else begin
                if (hold == 0) begin
                    sd_ack[rch] = 1'b0; on = 0; dly = $urandom_range(0, 8);
                end else hold--;
            end
            if (noise_en && $urandom_range(0, 3) == 0) sd_ack[1-rch] = ~sd_ack[1-rch];
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk_sys); #1;
    endtask

    task automatic clr_cnt();
        rd_n = '{0, 0}; wr_n = '{0, 0};
        done_n = 0; max_lba = 0; bkl_gap = 0; bkl_hi = 0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        tick();
        n = 1;
        while (busy && n < budget) begin tick(); n++; end
        chk({"idle_", name}, 64'(busy), 64'(0));
    endtask

    task automatic download(input logic [1:0] mnt, input int ls);
        last_sect = 15'(ls);
        rom_loading = 1; tick(); tick();
        img_size_nz = 1; img_readonly = 0; img_mounted = mnt; tick();
        img_mounted = '0; tick();
        clr_cnt();
        rom_loading = 0;
    endtask

    initial begin
        int n, rom_cnt, sil_cnt;
        logic found;
        reset_n = 0; rom_loading = 0; img_mounted = '0; img_readonly = 0; img_size_nz = 0;
        img_sel = '0; load_req = 0; save_req = 0; last_sect = '0; bsram_wr = 0;
        repeat (3) tick();
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ena", 64'(ena), 64'(0));
        chk("rst_req", 64'({sd_rd, sd_wr}), 64'(0));
        reset_n = 1;
        tick();

        // auto-load of image 0, four sectors
        download(2'b01, 3);
        wait_idle(2000, "autoload");
        chk("al_rd0", 64'(rd_n[0]), 64'(4));
        chk("al_wr", 64'(wr_n[0] + wr_n[1] + rd_n[1]), 64'(0));
        chk("al_done", 64'(done_n), 64'(1));
        chk("al_maxlba", 64'(max_lba), 64'(3));
        chk("al_bkl_gap", 64'(bkl_gap), 64'(0));
        chk("al_bkl_seen", 64'(bkl_hi > 0), 64'(1));
        chk("al_ena", 64'(ena), 64'(2'b01));

        // enable both images, then simultaneous load+save on image 1
        download(2'b11, 1);
        wait_idle(2000, "autoload2");
        chk("dl2_ena", 64'(ena), 64'(2'b11));
        img_sel = 1'b1; last_sect = 15'd2; clr_cnt();
        load_req = 1; save_req = 1;
        wait_idle(2000, "ldsv");
        chk("ldsv_rd1", 64'(rd_n[1]), 64'(3));
        chk("ldsv_other", 64'(rd_n[0] + wr_n[0] + wr_n[1]), 64'(0));
        chk("ldsv_done", 64'(done_n), 64'(1));
        load_req = 0; save_req = 0; tick();

        // save with no ack -> timeout
        silent = 1; img_sel = 1'b0; clr_cnt();
        save_req = 1;
        wait_idle(ACK_TO_I + 20, "timeout");
        chk("to_error", 64'(error), 64'(1));
        chk("to_wr", 64'(sd_wr), 64'(0));
        chk("to_done", 64'(done_n), 64'(0));
        chk("to_wr_pulses", 64'(wr_n[0]), 64'(1));
        save_req = 0; silent = 0; tick(); tick();
        chk("to_sticky", 64'(error), 64'(1));
        last_sect = '0; load_req = 1; tick();
        chk("to_clear", 64'(error), 64'(0));
        chk("to_clear_busy", 64'(busy), 64'(1));
        wait_idle(2000, "after_to");
        load_req = 0; tick();

        // abort during sector 2 of a load
        last_sect = 15'd5; clr_cnt(); load_req = 1;
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            tick();
            if (busy && sd_lba == 32'd2) found = 1;
        end
        chk("ab_reach2", 64'(found), 64'(1));
        rom_loading = 1; tick();
        chk("ab_busy", 64'(busy), 64'(0));
        chk("ab_bkl", 64'(bk_loading), 64'(0));
        chk("ab_ena", 64'(ena), 64'(0));
        chk("ab_req", 64'(sd_rd), 64'(0));
        chk("ab_nodone", 64'(done_n), 64'(0));
        load_req = 0;
        img_mounted = 2'b11; img_size_nz = 1; img_readonly = 0; tick();
        img_mounted = '0; last_sect = 15'd1; tick();
        rom_loading = 0;
        wait_idle(2000, "reload");

        // single-sector save
        last_sect = '0; img_sel = 1'b0; clr_cnt(); save_req = 1;
        wait_idle(2000, "onesect");
        chk("one_wr", 64'(wr_n[0]), 64'(1));
        chk("one_done", 64'(done_n), 64'(1));
        chk("one_lba", 64'(sd_lba), 64'(0));
        save_req = 0; tick();

        // randomized phase
        noise_en = 1; rom_cnt = 0; sil_cnt = 0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 7) == 0) img_sel = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 19) == 0) load_req = ~load_req;
            if ($urandom_range(0, 19) == 0) save_req = ~save_req;
            if ($urandom_range(0, 15) == 0) last_sect = 15'($urandom_range(0, 3));
            bsram_wr = ($urandom_range(0, 15) == 0);
            img_mounted = '0;
            if (rom_cnt > 0) begin
                rom_cnt--;
                if ($urandom_range(0, 3) == 0) begin
                    img_mounted = 2'($urandom_range(0, 3));
                    img_readonly = ($urandom_range(0, 3) == 0);
                    img_size_nz = ($urandom_range(0, 5) != 0);
                end
                if (rom_cnt == 0) rom_loading = 0;
            end else if ($urandom_range(0, 299) == 0) begin
                rom_loading = 1; rom_cnt = $urandom_range(3, 12);
            end
            if (sil_cnt > 0) begin
                sil_cnt--;
                if (sil_cnt == 0) silent = 0;
            end else if ($urandom_range(0, 499) == 0) begin
                silent = 1; sil_cnt = $urandom_range(80, 150);
            end
            tick();
        end
        noise_en = 0; silent = 0; rom_loading = 0; img_mounted = '0;
        load_req = 0; save_req = 0; bsram_wr = 0;
        repeat (5) tick();
        wait_idle(2000, "rand_end");

        // quiet period after BSRAM writes
        download(2'b01, 0);
        wait_idle(2000, "pre_auto");
        repeat (5) begin bsram_wr = 1; tick(); end
        bsram_wr = 0; clr_cnt();
`ifdef BK_AUTOSAVE_EN
        n = 0;
        while (wr_n[0] == 0 && n < 300) begin tick(); n++; end
        chk("auto_delay_ok", 64'(n >= AUTO_DLY_I && n <= AUTO_DLY_I + 2), 64'(1));
        wait_idle(2000, "autosave");
        chk("auto_done", 64'(done_n), 64'(1));
        clr_cnt();
        repeat (300) tick();
        chk("auto_norepeat", 64'(wr_n[0]), 64'(0));
`else
        n = 0;
        repeat (300) tick();
        chk("no_autosave", 64'(wr_n[0] + n), 64'(0));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
